// File: rtl/vga_tile_sched.sv
// vga_tile_sched: 640x480@60 raster timing plus tile-state prefetch and a shared tile-memory port.
// Define VGA_TILE_WR_VBLANK_ONLY_EN to restrict writer access to vertical blanking.
module vga_tile_sched #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TILE     = 20,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic [9:0]    col,
  output logic [9:0]    row,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          frame_start,
  output logic [DW-1:0] state_out,
  output logic [9:0]    mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          wr_req,
  input  logic [9:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack
);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_PRE   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 2);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HA      = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_PRE   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VA      = 10'(V_ACTIVE);
  localparam logic [4:0] T_LAST  = 5'(TILE - 1);
  localparam logic [4:0] T_PRE   = 5'(TILE - 2);
  localparam logic [5:0] TX_LAST = 6'(H_ACTIVE / TILE - 1);

  logic [9:0]    col_q, col_d, row_q, row_d;
  logic [4:0]    tile_px_q, tile_px_d, tile_py_q, tile_py_d;
  logic [5:0]    tile_col_q, tile_col_d;
  logic [4:0]    tile_row_q, tile_row_d, next_tile_row;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] state_q, state_d;
  logic          line_end, frame_end, tpx_end, tpy_end;
  logic          fetch_line, fetch_next, fetch, wr_ok;
  logic [9:0]    fetch_addr;

  always_comb begin
    line_end      = col_q == H_LAST;
    frame_end     = line_end && row_q == V_LAST;
    tpx_end       = tile_px_q == T_LAST;
    tpy_end       = tile_py_q == T_LAST;
    col_d         = line_end ? 10'd0 : col_q + 10'd1;
    row_d         = frame_end ? 10'd0 : line_end ? row_q + 10'd1 : row_q;
    tile_px_d     = (line_end || tpx_end) ? 5'd0 : tile_px_q + 5'd1;
    tile_col_d    = line_end ? 6'd0 : tpx_end ? tile_col_q + 6'd1 : tile_col_q;
    tile_py_d     = frame_end ? 5'd0 : line_end ? (tpy_end ? 5'd0 : tile_py_q + 5'd1) : tile_py_q;
    tile_row_d    = frame_end ? 5'd0 : (line_end && tpy_end) ? tile_row_q + 5'd1 : tile_row_q;
    hsync_d       = !(col_d >= HS_BEG && col_d < HS_END);
    vsync_d       = !(row_d >= VS_BEG && row_d < VS_END);
    active_d      = col_d < HA && row_d < VA;
    // Tile 0 of the next line is fetched two cycles before the line wraps.
    next_tile_row = row_q == V_LAST ? 5'd0 : tpy_end ? tile_row_q + 5'd1 : tile_row_q;
    fetch_line    = !reset && row_q < VA && tile_px_q == T_PRE && tile_col_q < TX_LAST;
    fetch_next    = !reset && col_q == H_PRE && (row_q < V_PRE || row_q == V_LAST);
    fetch         = fetch_line || fetch_next;
    fetch_addr    = fetch_next ? {next_tile_row, 5'd0} : {tile_row_q, tile_col_q[4:0] + 5'd1};
`ifdef VGA_TILE_WR_VBLANK_ONLY_EN
    wr_ok         = row_q >= VA;
`else
    wr_ok         = 1'b1;
`endif
    wr_ack        = !reset && !fetch && wr_req && wr_ok;
    mem_re        = fetch;
    mem_we        = wr_ack;
    mem_addr      = fetch ? fetch_addr : wr_addr;
    mem_wdata     = wr_data;
    rd_pend_d     = fetch;
    state_d       = rd_pend_q ? mem_rdata : state_q;
    frame_start   = !reset && col_q == 10'd0 && row_q == 10'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      tile_px_q  <= '0;
      tile_col_q <= '0;
      tile_py_q  <= '0;
      tile_row_q <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      active_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      state_q    <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      tile_px_q  <= tile_px_d;
      tile_col_q <= tile_col_d;
      tile_py_q  <= tile_py_d;
      tile_row_q <= tile_row_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      active_q   <= active_d;
      rd_pend_q  <= rd_pend_d;
      state_q    <= state_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign active    = active_q;
  assign state_out = state_q;
endmodule
